// File: rtl/fir_sample_feeder.sv
// Sample FIFO that hands one sample per filter frame to the FIR MAC.
// Holds xn steady across a frame, pulses frame_start, flags underrun.
//
// Ports:
//   clk, global_reset     clock, async active-high reset
//   in_data/valid/ready   upstream sample handshake
//   run                   frame counter enable
//   clr_underrun          clears the sticky underrun flag
//   xn                    sample for the current frame
//   frame_start           pulse in the first cycle of a new xn
//   underrun              sticky: a boundary found the FIFO empty
//   level                 FIFO occupancy, 0..DEPTH
module fir_sample_feeder #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int FRAME_LEN = 5
) (
    input  logic                     clk,
    input  logic                     global_reset,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     run,
    input  logic                     clr_underrun,
    output logic [DATA_W-1:0]        xn,
    output logic                     frame_start,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(FRAME_LEN);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] xn_q, xn_d;
    logic              fs_q, fs_d;
    logic              un_q, un_d;

    logic boundary;
    logic empty;
    logic push;
    logic pop;

    assign in_ready    = (level_q != LVL_FULL);
    assign xn          = xn_q;
    assign frame_start = fs_q;
    assign underrun    = un_q;
    assign level       = level_q;

    assign boundary = run && (cnt_q == CNT_LAST);
    assign empty    = (level_q == '0);
    assign push     = in_valid && in_ready;
    // Pop decides on the pre-edge level, so a push on the same
    // edge into an empty FIFO is never bypassed to xn.
    assign pop      = boundary && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        xn_d     = xn_q;
        fs_d     = 1'b0;
        un_d     = un_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (run) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (clr_underrun) begin
            un_d = 1'b0;
        end

        if (boundary) begin
            fs_d = 1'b1;
            if (pop) begin
                xn_d     = mem[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                // Zero-stuff so the filter keeps its frame timing.
                xn_d = '0;
                un_d = 1'b1;
            end
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge global_reset) begin
        if (global_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            xn_q     <= '0;
            fs_q     <= 1'b0;
            un_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            xn_q     <= xn_d;
            fs_q     <= fs_d;
            un_q     <= un_d;
        end
    end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Scoreboard bench for fir_sample_feeder.
// Queue-based reference model, negedge monitor, randomized traffic.
module tb_fir_sample_feeder;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 8;
    localparam int FRAME_LEN = 5;

    logic              clk;
    logic              global_reset;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              run;
    logic              clr_underrun;
    logic [DATA_W-1:0] xn;
    logic              frame_start;
    logic              underrun;
    logic [3:0]        level;

    fir_sample_feeder #(
        .DATA_W(DATA_W),
        .DEPTH(DEPTH),
        .FRAME_LEN(FRAME_LEN)
    ) dut (
        .clk(clk),
        .global_reset(global_reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .run(run),
        .clr_underrun(clr_underrun),
        .xn(xn),
        .frame_start(frame_start),
        .underrun(underrun),
        .level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a queue of samples, a run-cycle count, and
    // the list of xn values each boundary is expected to present.
    logic [DATA_W-1:0] m_fifo [$];
    logic [DATA_W-1:0] sb     [$];
    int                m_cnt = 0;
    logic [DATA_W-1:0] m_xn  = '0;
    bit                m_fs  = 0;
    bit                m_un  = 0;

    initial begin
        bit          bnd;
        bit          can_push;
        logic [7:0]  v;
        forever begin
            @(posedge clk or posedge global_reset);
            if (global_reset) begin
                m_fifo.delete();
                sb.delete();
                m_cnt = 0;
                m_xn  = '0;
                m_fs  = 0;
                m_un  = 0;
            end else begin
                bnd      = run && (m_cnt == FRAME_LEN - 1);
                can_push = (m_fifo.size() < DEPTH);
                m_fs     = 0;
                if (clr_underrun) m_un = 0;
                if (bnd) begin
                    if (m_fifo.size() > 0) begin
                        v = m_fifo.pop_front();
                    end else begin
                        v    = '0;
                        m_un = 1;
                    end
                    m_xn = v;
                    m_fs = 1;
                    sb.push_back(v);
                end
                if (in_valid && can_push) m_fifo.push_back(in_data);
                if (run) m_cnt = (m_cnt + 1) % FRAME_LEN;
            end
        end
    end

    initial begin
        logic [DATA_W-1:0] e;
        forever begin
            @(negedge clk);
            check("level", 32'(level), 32'(m_fifo.size()));
            check("in_ready", 32'(in_ready),
                  32'(m_fifo.size() != DEPTH));
            check("underrun", 32'(underrun), 32'(m_un));
            check("frame_start", 32'(frame_start), 32'(m_fs));
            check("xn_hold", 32'(xn), 32'(m_xn));
            if (frame_start === 1'b1) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_frame", 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    check("sb_xn", 32'(xn), 32'(e));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        bit r;
        bit done;
        done     = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 300 && !done; i++) begin
            r = in_ready;
            step();
            done = r;
        end
        in_valid = 1'b0;
        if (!done) check("push_timeout", 32'(0), 32'(1));
    endtask

    task automatic clr_safe();
        bit ok;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (!run || m_cnt != FRAME_LEN - 1) ok = 1;
            else step();
        end
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_xn"}, 32'(xn), 32'(0));
        check({tag, "_level"}, 32'(level), 32'(0));
        check({tag, "_in_ready"}, 32'(in_ready), 32'(1));
        check({tag, "_underrun"}, 32'(underrun), 32'(0));
        check({tag, "_frame_start"}, 32'(frame_start), 32'(0));
    endtask

    initial begin
        int n;
        bit seen;
        global_reset = 1'b1;
        in_data      = '0;
        in_valid     = 1'b0;
        run          = 1'b0;
        clr_underrun = 1'b0;
        #1;
        check_reset_vals("rst0");
        repeat (2) @(posedge clk);
        #3 global_reset = 1'b0;

        // Single sample
        run = 1'b1;
        push(8'h12);
        repeat (14) step();

        // Stream ordering with pointer wrap
        run = 1'b0;
        clr_safe();
        for (int i = 1; i <= 4; i++) push(8'(i));
        run = 1'b1;
        for (int i = 5; i <= 12; i++) begin
            push(8'(i));
            repeat (FRAME_LEN - 1) step();
        end
        check("stream_no_underrun", 32'(underrun), 32'(0));
        repeat (40) step();

        // Full FIFO and backpressure
        run = 1'b0;
        clr_safe();
        for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
        check("full_level", 32'(level), 32'(8));
        check("full_in_ready", 32'(in_ready), 32'(0));
        fork
            push(8'hA8);
            begin
                repeat (3) step();
                run = 1'b1;
            end
        join
        repeat (50) step();

        // Underrun and clear
        repeat (3 * FRAME_LEN) step();
        check("underrun_set", 32'(underrun), 32'(1));
        clr_safe();
        check("underrun_clr", 32'(underrun), 32'(0));

        // Reset mid-operation
        run = 1'b0;
        for (int i = 0; i < 3; i++) push(8'h30 + 8'(i));
        run = 1'b1;
        repeat (2) step();
        run = 1'b0;
        #1 global_reset = 1'b1;
        #1;
        check_reset_vals("rst_mid");
        run = 1'b1;
        @(posedge clk);
        #3 global_reset = 1'b0;
        n = 0;
        step();
        n++;
        in_valid = 1'b1;
        in_data  = 8'h55;
        seen     = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            n++;
            #2 in_valid = 1'b0;
            #1;
            if (frame_start) seen = 1;
        end
        check("rst_first_frame_cycles", 32'(n), 32'(FRAME_LEN));
        check("rst_first_xn", 32'(xn), 32'(8'h55));

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            step();
            in_valid     = 1'($urandom_range(0, 1));
            in_data      = 8'($urandom);
            run          = ($urandom_range(0, 7) != 0);
            clr_underrun = ($urandom_range(0, 15) == 0);
        end
        in_valid     = 1'b0;
        clr_underrun = 1'b0;
        @(negedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_sample_feeder.md
Name: fir_sample_feeder

Overview:
Producer-side partner of the FIR MAC filter. It accepts input samples from an upstream source over a valid/ready handshake and buffers them in a small FIFO. It presents exactly one sample per filter frame on xn, held stable for the whole frame, so the filter's RAM write and MAC sequence always sees a steady input. It emits a frame-start strobe aligned with each new sample and flags underrun when no sample is available at a frame boundary.

Parameters:
DATA_W, 8, sample width; matches filter xn width
DEPTH, 8, FIFO depth in samples; power of 2, minimum 2
FRAME_LEN, 5, clock cycles per filter frame (TAPS+1 for the 4-tap filter); minimum 2

Ports:
clk  input  1  system clock, rising edge
global_reset  input  1  asynchronous, active-high reset
in_data  input  DATA_W  upstream sample
in_valid  input  1  upstream sample valid
in_ready  output  1  feeder can accept a sample
run  input  1  frame counter enable
clr_underrun  input  1  clears underrun sticky flag
xn  output  DATA_W  sample to filter, constant within a frame
frame_start  output  1  one-cycle pulse in the first cycle a new xn is presented
underrun  output  1  sticky: a frame boundary found the FIFO empty
level  output  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (asynchronous, active-high): FIFO empty, level=0, rd/wr pointers=0, frame counter=0, xn=0, frame_start=0, underrun=0. All state is registered; there is no synchronous reset path.
- in_ready = (level != DEPTH), combinational from registered level. It is never gated by in_valid.
- Push: in_valid & in_ready at a rising edge writes in_data at wr_ptr, and wr_ptr increments modulo DEPTH.
- Frame counter: runs 0..FRAME_LEN-1, wraps to 0, and advances only when run=1. When run=0 the counter, xn and FIFO read side freeze, and pushes continue.
- Frame boundary = (run=1 and counter==FRAME_LEN-1) at a rising edge. At a boundary:
  - FIFO non-empty: xn <= mem[rd_ptr], rd_ptr increments modulo DEPTH, and frame_start=1 in the following cycle.
  - FIFO empty: xn <= 0 (zero-stuffed sample keeps filter timing), underrun <= 1, and frame_start=1 in the following cycle.
- frame_start is 0 at all other times. Latency from a boundary edge to new xn and frame_start is 0 cycles after that edge, and both are registered outputs.
- Simultaneous push and pop in the same edge: level is unchanged, and both pointers advance.
- Push into an empty FIFO on a boundary edge: the pop sees empty (no bypass), so xn=0 and underrun=1. The pushed sample is presented at the next boundary.
- Full FIFO with a pop on the same edge: in_ready was 0, so no push occurs and level decrements by 1.
- underrun: set on an empty boundary and cleared by clr_underrun=1. If a set and clear fall on the same edge, set wins.
- level width holds 0..DEPTH inclusive. Pointer wrap-around must not corrupt data ordering; output order is strictly FIFO.
- Reset asserted mid-frame: all state clears immediately. After deassertion the first boundary occurs FRAME_LEN run-cycles later.
- After reset, the first xn load happens at the first boundary, not at cycle 0.

Test Plan:
1. Reset values: assert global_reset asynchronously mid-cycle -> xn=0x00, level=0, in_ready=1, underrun=0, frame_start=0 immediately, without waiting for a clk edge.
2. Single sample: run=1, push 0x12 at cycle 1 -> level=1. At the first boundary (edge 5), xn=0x12, frame_start=1 for one cycle, level=0. xn holds 0x12 for 5 cycles.
3. Stream ordering with wrap: push 0x01..0x0C paced one per frame after pre-filling 4 -> xn sequence is exactly 0x01..0x0C with pointers wrapping past 7, and no underrun.
4. Full/backpressure: run=0, in_valid=1 with 0xA0..0xA8 -> 8 accepted, level=8, in_ready=0, 0xA8 held. Set run=1 -> after the first pop 0xA8 is accepted and all nine appear in order.
5. Underrun: run=1 with an empty FIFO -> at each boundary xn=0x00, frame_start pulses, underrun=1 and stays set. Pulse clr_underrun with no boundary that cycle -> underrun=0.
6. Reset mid-operation: level=3, counter=2, assert global_reset -> all cleared. After release, push 0x55 -> xn=0x55 exactly 5 run-cycles after release.
